ball_motion: RTL and testbench

- Consumer of the periodic 1-cycle movement pulse from the game timing generator (one `tick` every 150 000 `CLOCK_50` cycles).
- Advances the pong ball by one pixel per axis on each tick.
- Reflects the ball off the top/bottom walls and off both paddles, and detects misses.
- Feeds the VGA renderer (ball position) and the score counters (miss pulses).

---
 rtl/ball_motion_if.sv | 24 ++
 rtl/ball_motion.sv | 176 +++++++++++++++++
 tb/tb_ball_motion.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/ball_motion_if.sv
// Signal bundle between the game logic and the pong ball mover.
// The master drives timing, serve and paddle rows; the slave returns the ball state.
interface ball_motion_if;
  logic       tick;
  logic       serve;
  logic       pause;
  logic [9:0] paddle_l_y;
  logic [9:0] paddle_r_y;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       score_l;
  logic       score_r;
  logic       running;

  modport master (
    output tick, serve, pause, paddle_l_y, paddle_r_y,
    input  ball_x, ball_y, score_l, score_r, running
  );

  modport slave (
    input  tick, serve, pause, paddle_l_y, paddle_r_y,
    output ball_x, ball_y, score_l, score_r, running
  );
endinterface

// File: rtl/ball_motion.sv
// Pong ball mover: one pixel per axis per tick, with wall and paddle reflection and miss detection.
// Serve/run/scored sequencing; all outputs are registered.
module ball_motion #(
  parameter int H_ACTIVE       = 640,
  parameter int V_ACTIVE       = 480,
  parameter int BALL_SIZE      = 8,
  parameter int PADDLE_W       = 8,
  parameter int PADDLE_H       = 64,
  parameter int LEFT_PADDLE_X  = 16,
  parameter int RIGHT_PADDLE_X = 616
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  ball_motion_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    SCORED = 2'd2
  } state_t;

  localparam logic [9:0] CENTRE_X = 10'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0] CENTRE_Y = 10'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0] X_MAX    = 10'(H_ACTIVE - BALL_SIZE);
  localparam logic [9:0] Y_MAX    = 10'(V_ACTIVE - BALL_SIZE);
  localparam logic [9:0] L_FACE   = 10'(LEFT_PADDLE_X + PADDLE_W);
  localparam logic [9:0] R_FACE   = 10'(RIGHT_PADDLE_X - BALL_SIZE);

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;

  state_t     state_q, state_d;
  logic [9:0] ball_x_q, ball_x_d;
  logic [9:0] ball_y_q, ball_y_d;
  logic       dir_x_q, dir_x_d;
  logic       dir_y_q, dir_y_d;
  logic       score_l_q, score_l_d;
  logic       score_r_q, score_r_d;
  logic       running_q, running_d;

  // Index 0 is the left paddle, index 1 the right paddle.
  logic [9:0]  paddle_y [2];
  logic [1:0]  overlap;
  logic [10:0] ball_top;
  logic [10:0] ball_bot;

  assign paddle_y[0] = bus.paddle_l_y;
  assign paddle_y[1] = bus.paddle_r_y;
  assign ball_top    = {1'b0, ball_y_q};
  assign ball_bot    = ball_top + 11'(BALL_SIZE);

  // Widened compares so a paddle near the bottom cannot wrap.
  for (genvar gi = 0; gi < 2; gi++) begin : g_overlap
    logic [10:0] pad_top;
    logic [10:0] pad_bot;
    assign pad_top     = {1'b0, paddle_y[gi]};
    assign pad_bot     = pad_top + 11'(PADDLE_H);
    assign overlap[gi] = (ball_bot > pad_top) && (ball_top < pad_bot);
  end

  logic move;
  assign move = (state_q == RUN) && bus.tick && !bus.pause;

  always_comb begin
    state_d   = state_q;
    ball_x_d  = ball_x_q;
    ball_y_d  = ball_y_q;
    dir_x_d   = dir_x_q;
    dir_y_d   = dir_y_q;
    score_l_d = 1'b0;
    score_r_d = 1'b0;

    case (state_q)
      IDLE: begin
        ball_x_d = CENTRE_X;
        ball_y_d = CENTRE_Y;
        if (bus.serve) begin
          state_d = RUN;
        end
      end

      RUN: begin
        if (move) begin
          if (dir_y_q == DIR_UP) begin
            if (ball_y_q == 10'd0) begin
              dir_y_d  = DIR_DOWN;
              ball_y_d = 10'd1;
            end else begin
              ball_y_d = ball_y_q - 10'd1;
            end
          end else begin
            if (ball_y_q == Y_MAX) begin
              dir_y_d  = DIR_UP;
              ball_y_d = Y_MAX - 10'd1;
            end else begin
              ball_y_d = ball_y_q + 10'd1;
            end
          end

          // A miss still takes the y step; x is frozen where the ball left play.
          if (dir_x_q == DIR_LEFT) begin
            if ((ball_x_q == L_FACE) && overlap[0]) begin
              dir_x_d  = DIR_RIGHT;
              ball_x_d = L_FACE + 10'd1;
            end else if (ball_x_q == 10'd0) begin
              score_r_d = 1'b1;
              dir_x_d   = DIR_LEFT;
              state_d   = SCORED;
            end else begin
              ball_x_d = ball_x_q - 10'd1;
            end
          end else begin
            if ((ball_x_q == R_FACE) && overlap[1]) begin
              dir_x_d  = DIR_LEFT;
              ball_x_d = R_FACE - 10'd1;
            end else if (ball_x_q == X_MAX) begin
              score_l_d = 1'b1;
              dir_x_d   = DIR_RIGHT;
              state_d   = SCORED;
            end else begin
              ball_x_d = ball_x_q + 10'd1;
            end
          end
        end
      end

      SCORED: begin
        if (bus.tick) begin
          state_d  = IDLE;
          ball_x_d = CENTRE_X;
          ball_y_d = CENTRE_Y;
        end
      end

      default: begin
        state_d  = IDLE;
        ball_x_d = CENTRE_X;
        ball_y_d = CENTRE_Y;
      end
    endcase

    running_d = (state_d == RUN);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= IDLE;
      ball_x_q  <= CENTRE_X;
      ball_y_q  <= CENTRE_Y;
      dir_x_q   <= DIR_RIGHT;
      dir_y_q   <= DIR_DOWN;
      score_l_q <= 1'b0;
      score_r_q <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ball_x_q  <= ball_x_d;
      ball_y_q  <= ball_y_d;
      dir_x_q   <= dir_x_d;
      dir_y_q   <= dir_y_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      running_q <= running_d;
    end
  end

  assign bus.ball_x  = ball_x_q;
  assign bus.ball_y  = ball_y_q;
  assign bus.score_l = score_l_q;
  assign bus.score_r = score_r_q;
  assign bus.running = running_q;

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: a vector table walks one long rally through walls,
// both paddles, a left miss and the re-serve, followed by short serve/reset sequences.
module tb_ball_motion;

  logic clk = 1'b0;
  logic reset = 1'b1;

  ball_motion_if bus ();

  ball_motion dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic       rst;
    logic       srv;
    logic       pse;
    logic [9:0] pl;
    logic [9:0] pr;
    logic [9:0] ex;
    logic [9:0] ey;
    logic       esl;
    logic       esr;
    logic       erun;
  } vec_t;

  localparam int NVEC = 29;
  vec_t vecs [NVEC];

  int checks = 0;
  int fails  = 0;

  function automatic vec_t mk(input int n, input logic rst, input logic srv, input logic pse,
                              input logic [9:0] pl, input logic [9:0] pr,
                              input logic [9:0] ex, input logic [9:0] ey,
                              input logic esl, input logic esr, input logic erun);
    vec_t v;
    v.n = n; v.rst = rst; v.srv = srv; v.pse = pse; v.pl = pl; v.pr = pr;
    v.ex = ex; v.ey = ey; v.esl = esl; v.esr = esr; v.erun = erun;
    return v;
  endfunction

  task automatic check(input string name, input logic [9:0] ex, input logic [9:0] ey,
                       input logic esl, input logic esr, input logic erun);
    checks++;
    if ({bus.ball_x, bus.ball_y, bus.score_l, bus.score_r, bus.running} !== {ex, ey, esl, esr, erun}) begin
      fails++;
      $display("FAIL %s: got x=%0d y=%0d sl=%b sr=%b run=%b, expected x=%0d y=%0d sl=%b sr=%b run=%b",
               name, bus.ball_x, bus.ball_y, bus.score_l, bus.score_r, bus.running,
               ex, ey, esl, esr, erun);
    end else begin
      $display("ok   %s: x=%0d y=%0d sl=%b sr=%b run=%b",
               name, bus.ball_x, bus.ball_y, bus.score_l, bus.score_r, bus.running);
    end
  endtask

  // Called on a negedge; n ticks are spaced one idle cycle apart, n==0 is one plain cycle.
  task automatic run_vec(input vec_t v);
    int cyc;
    cyc = (v.n == 0) ? 1 : v.n;
    reset          = v.rst;
    bus.serve      = v.srv;
    bus.pause      = v.pse;
    bus.paddle_l_y = v.pl;
    bus.paddle_r_y = v.pr;
    for (int i = 0; i < cyc; i++) begin
      bus.tick = (v.n != 0);
      @(negedge clk);
      bus.tick = 1'b0;
      if (i != cyc - 1) @(negedge clk);
    end
    reset     = 1'b0;
    bus.serve = 1'b0;
  endtask

  initial begin
    bus.tick       = 1'b0;
    bus.serve      = 1'b0;
    bus.pause      = 1'b0;
    bus.paddle_l_y = 10'd0;
    bus.paddle_r_y = 10'd412;

    //                 n   rst  srv  pse  pl   pr    x    y    sl sr run
    vecs[0]  = mk(  0, 1'b1, 1'b0, 1'b0,   0, 412, 316, 236, 0, 0, 0); // reset state
    vecs[1]  = mk(  5, 1'b0, 1'b0, 1'b0,   0, 412, 316, 236, 0, 0, 0); // IDLE ignores ticks
    vecs[2]  = mk(  0, 1'b0, 1'b1, 1'b0,   0, 412, 316, 236, 0, 0, 1); // serve
    vecs[3]  = mk(  1, 1'b0, 1'b0, 1'b0,   0, 412, 317, 237, 0, 0, 1);
    vecs[4]  = mk(  3, 1'b0, 1'b0, 1'b1,   0, 412, 317, 237, 0, 0, 1); // paused ticks dropped
    vecs[5]  = mk(234, 1'b0, 1'b0, 1'b0,   0, 412, 551, 471, 0, 0, 1);
    vecs[6]  = mk(  1, 1'b0, 1'b0, 1'b0,   0, 412, 552, 472, 0, 0, 1); // bottom wall
    vecs[7]  = mk(  1, 1'b0, 1'b0, 1'b0,   0, 412, 553, 471, 0, 0, 1);
    vecs[8]  = mk( 54, 1'b0, 1'b0, 1'b0,   0, 412, 607, 417, 0, 0, 1);
    vecs[9]  = mk(  1, 1'b0, 1'b0, 1'b0,   0, 412, 608, 416, 0, 0, 1); // right paddle face
    vecs[10] = mk(  1, 1'b0, 1'b0, 1'b0,   0, 412, 607, 415, 0, 0, 1);
    vecs[11] = mk(414, 1'b0, 1'b0, 1'b0,   0, 412, 193,   1, 0, 0, 1);
    vecs[12] = mk(  1, 1'b0, 1'b0, 1'b0,   0, 412, 192,   0, 0, 0, 1); // top wall
    vecs[13] = mk(  1, 1'b0, 1'b0, 1'b0,   0, 412, 191,   1, 0, 0, 1);
    vecs[14] = mk(190, 1'b0, 1'b0, 1'b0,   0, 412,   1, 191, 0, 0, 1); // passes x=24, paddle away
    vecs[15] = mk(  1, 1'b0, 1'b0, 1'b0,   0, 412,   0, 192, 0, 0, 1);
    vecs[16] = mk(  1, 1'b0, 1'b0, 1'b0,   0, 412,   0, 193, 0, 1, 0); // left miss
    vecs[17] = mk(  0, 1'b0, 1'b0, 1'b0,   0, 412,   0, 193, 0, 0, 0); // pulse one cycle wide
    vecs[18] = mk(  0, 1'b0, 1'b1, 1'b0,   0, 412,   0, 193, 0, 0, 0); // serve ignored in SCORED
    vecs[19] = mk(  1, 1'b0, 1'b0, 1'b0,   0, 412, 316, 236, 0, 0, 0); // re-centre to IDLE
    vecs[20] = mk(  0, 1'b0, 1'b1, 1'b0,   0, 412, 316, 236, 0, 0, 1);
    vecs[21] = mk(  1, 1'b0, 1'b0, 1'b0,   0, 412, 315, 237, 0, 0, 1); // re-serve heads left
    vecs[22] = mk(290, 1'b0, 1'b0, 1'b0, 412, 412,  25, 417, 0, 0, 1);
    vecs[23] = mk(  1, 1'b0, 1'b0, 1'b0, 412, 412,  24, 416, 0, 0, 1); // left paddle face
    vecs[24] = mk(  1, 1'b0, 1'b0, 1'b0, 412, 412,  25, 415, 0, 0, 1);
    vecs[25] = mk(  3, 1'b0, 1'b0, 1'b0, 412, 412,  28, 412, 0, 0, 1);
    vecs[26] = mk(  1, 1'b1, 1'b0, 1'b0, 412, 412, 316, 236, 0, 0, 0); // reset beats tick
    vecs[27] = mk(  0, 1'b0, 1'b1, 1'b0, 412, 412, 316, 236, 0, 0, 1);
    vecs[28] = mk(  1, 1'b0, 1'b0, 1'b0, 412, 412, 317, 237, 0, 0, 1); // dirs back to right/down

    @(negedge clk);
    for (int i = 0; i < NVEC; i++) begin
      run_vec(vecs[i]);
      check($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey, vecs[i].esl, vecs[i].esr, vecs[i].erun);
    end

    // Mid-rally reset, then a serve coinciding with a tick: that tick must not move the ball.
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
    check("pre_reset_move", 10'd318, 10'd238, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset_idle", 10'd316, 10'd236, 1'b0, 1'b0, 1'b0);
    bus.serve = 1'b1;
    bus.tick  = 1'b1;
    @(negedge clk);
    bus.serve = 1'b0;
    bus.tick  = 1'b0;
    check("serve_with_tick", 10'd316, 10'd236, 1'b0, 1'b0, 1'b1);
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
    check("first_step", 10'd317, 10'd237, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("hold_no_tick", 10'd317, 10'd237, 1'b0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
